// File: rtl/debounce_sync.sv
// Two-flop synchronizer followed by a four-state debounce FSM.
// A new level is accepted only after STABLE_CNT consecutive matching samples.
module debounce_sync #(
  parameter int STABLE_CNT = 4,
  parameter int CNT_W      = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  localparam logic [2:0] LOW    = 3'b000;
  localparam logic [2:0] ARM_HI = 3'b001;
  localparam logic [2:0] HIGH   = 3'b010;
  localparam logic [2:0] ARM_LO = 3'b011;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             s1;
  logic             s2;
  logic [2:0]       state;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
    end
  end

  // The ARM states count consecutive samples of the candidate level; one opposite sample aborts.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LOW;
      cnt   <= '0;
      dout  <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      case (state)
        LOW: begin
          if (s2) begin
            state <= ARM_HI;
            cnt   <= CNT_ONE;
          end else begin
            cnt <= '0;
          end
        end
        ARM_HI: begin
          if (!s2) begin
            state <= LOW;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= HIGH;
            dout  <= 1'b1;
            rise  <= 1'b1;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        HIGH: begin
          if (!s2) begin
            state <= ARM_LO;
            cnt   <= CNT_ONE;
          end else begin
            cnt <= '0;
          end
        end
        ARM_LO: begin
          if (s2) begin
            state <= HIGH;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= LOW;
            dout  <= 1'b0;
            fall  <= 1'b1;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          state <= LOW;
          cnt   <= '0;
          dout  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_debounce_sync.sv
// Drives two debouncers (STABLE_CNT=4 and 2) from one din and compares them each cycle
// against a run-length reference model, plus directed latency and pulse-count checks.
module tb_debounce_sync;

  logic clk;
  logic rst;
  logic din;
  logic dout_a, rise_a, fall_a;
  logic dout_b, rise_b, fall_b;

  int total_checks;
  int bad_checks;
  int edge_no;

  int stable_of [2];
  bit m_s1   [2];
  bit m_s2   [2];
  bit m_dout [2];
  bit m_rise [2];
  bit m_fall [2];
  int m_run  [2];

  debounce_sync #(.STABLE_CNT(4), .CNT_W(16)) dut_a (
    .clk (clk),
    .rst (rst),
    .din (din),
    .dout(dout_a),
    .rise(rise_a),
    .fall(fall_a)
  );

  debounce_sync #(.STABLE_CNT(2), .CNT_W(8)) dut_b (
    .clk (clk),
    .rst (rst),
    .din (din),
    .dout(dout_b),
    .rise(rise_b),
    .fall(fall_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_checks++;
    if (got !== exp) begin
      bad_checks++;
      $display("[TB] FAIL %s got=%0h exp=%0h edge=%0d", tag, got, exp, edge_no);
    end
  endtask

  // Reference: the synchronized sample lags din by two edges; dout flips once the run of
  // consecutive samples differing from dout reaches STABLE_CNT.
  task automatic modelStep(input bit d, input bit r);
    bit s2_now;
    for (int i = 0; i < 2; i++) begin
      if (r) begin
        m_s1[i] = 1'b0; m_s2[i] = 1'b0; m_dout[i] = 1'b0;
        m_rise[i] = 1'b0; m_fall[i] = 1'b0; m_run[i] = 0;
      end else begin
        s2_now    = m_s2[i];
        m_s2[i]   = m_s1[i];
        m_s1[i]   = d;
        m_rise[i] = 1'b0;
        m_fall[i] = 1'b0;
        if (s2_now != m_dout[i]) begin
          m_run[i]++;
          if (m_run[i] == stable_of[i]) begin
            m_dout[i] = ~m_dout[i];
            if (m_dout[i]) m_rise[i] = 1'b1;
            else           m_fall[i] = 1'b1;
            m_run[i] = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
    end
  endtask

  task automatic applyStimulus(input bit d, input bit r);
    din = d;
    rst = r;
    @(posedge clk);
    #1;
    edge_no++;
    modelStep(d, r);
    checkOutput("a_dout", dout_a, m_dout[0]);
    checkOutput("a_rise", rise_a, m_rise[0]);
    checkOutput("a_fall", fall_a, m_fall[0]);
    checkOutput("b_dout", dout_b, m_dout[1]);
    checkOutput("b_rise", rise_b, m_rise[1]);
    checkOutput("b_fall", fall_b, m_fall[1]);
  endtask

  initial begin
    int  last_din_edge;
    int  rise_cnt;
    int  fall_cnt;
    int  fall_a_cnt;
    bit  prev_din;
    bit  prev_dout_b;
    bit  d;
    int  run_len;

    total_checks = 0;
    bad_checks   = 0;
    edge_no      = 0;
    stable_of[0] = 4;
    stable_of[1] = 2;
    for (int i = 0; i < 2; i++) begin
      m_s1[i] = 1'b0; m_s2[i] = 1'b0; m_dout[i] = 1'b0;
      m_rise[i] = 1'b0; m_fall[i] = 1'b0; m_run[i] = 0;
    end
    din = 1'b0;
    rst = 1'b1;

    // Reset, then din=1 from edge 0: dout and rise after edge 5, rise gone after edge 6.
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1);
    checkOutput("rst_dout", dout_a, 1'b0);
    checkOutput("rst_rise", rise_a, 1'b0);
    checkOutput("rst_fall", fall_a, 1'b0);
    for (int e = 0; e <= 6; e++) begin
      applyStimulus(1'b1, 1'b0);
      if (e == 4) checkOutput("lat_e4_dout", dout_a, 1'b0);
      if (e == 5) begin
        checkOutput("lat_e5_dout", dout_a, 1'b1);
        checkOutput("lat_e5_rise", rise_a, 1'b1);
      end
      if (e == 6) checkOutput("lat_e6_rise", rise_a, 1'b0);
      checkOutput("lat_fall", fall_a, 1'b0);
    end

    // Return low, then a 3-cycle glitch must not change dout_a.
    for (int e = 0; e < 10; e++) applyStimulus(1'b0, 1'b0);
    checkOutput("low_again", dout_a, 1'b0);
    for (int e = 0; e < 13; e++) begin
      applyStimulus(e < 3, 1'b0);
      checkOutput("glitch_dout", dout_a, 1'b0);
      checkOutput("glitch_rise", rise_a, 1'b0);
      checkOutput("glitch_fall", fall_a, 1'b0);
    end

    // dout_a high, 20 cycles of toggling, then hold 0: a single fall 5 edges in.
    for (int e = 0; e < 8; e++) applyStimulus(1'b1, 1'b0);
    checkOutput("pre_toggle", dout_a, 1'b1);
    for (int e = 0; e < 20; e++) begin
      applyStimulus(e[0], 1'b0);
      checkOutput("toggle_dout", dout_a, 1'b1);
    end
    fall_a_cnt = 0;
    for (int e = 0; e < 10; e++) begin
      applyStimulus(1'b0, 1'b0);
      fall_a_cnt += int'(fall_a);
      if (e == 4) checkOutput("hold_e4_dout", dout_a, 1'b1);
      if (e == 5) checkOutput("hold_e5_dout", dout_a, 1'b0);
    end
    checkOutput("hold_fall_cnt", fall_a_cnt, 1);

    // Reset in the middle of ARM_HI qualification, then din=1 qualifies afresh.
    for (int e = 0; e < 4; e++) applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1);
    checkOutput("midrst_dout", dout_a, 1'b0);
    checkOutput("midrst_rise", rise_a, 1'b0);
    checkOutput("midrst_fall", fall_a, 1'b0);
    for (int e = 0; e <= 5; e++) begin
      applyStimulus(1'b1, 1'b0);
      if (e == 4) checkOutput("postrst_e4", dout_a, 1'b0);
      if (e == 5) checkOutput("postrst_e5", dout_a, 1'b1);
    end

    // STABLE_CNT=2 instance: 10-high/10-low phases, every dout edge lags by 3 edges.
    applyStimulus(1'b0, 1'b1);
    prev_din      = 1'b0;
    prev_dout_b   = 1'b0;
    last_din_edge = edge_no;
    rise_cnt      = 0;
    fall_cnt      = 0;
    for (int c = 0; c < 110; c++) begin
      d = (c < 100) && (((c / 10) % 2) == 0);
      if (d != prev_din) last_din_edge = edge_no + 1;
      prev_din = d;
      applyStimulus(d, 1'b0);
      rise_cnt += int'(rise_b);
      fall_cnt += int'(fall_b);
      if (dout_b != prev_dout_b) checkOutput("b_lag", edge_no - last_din_edge, 3);
      prev_dout_b = dout_b;
    end
    checkOutput("b_rise_cnt", rise_cnt, 5);
    checkOutput("b_fall_cnt", fall_cnt, 5);

    // Random runs of varying length with occasional resets.
    for (int c = 0; c < 400; c += run_len) begin
      run_len = $urandom_range(1, 7);
      d = 1'($urandom_range(0, 1));
      for (int k = 0; k < run_len; k++)
        applyStimulus(d, $urandom_range(0, 59) == 0);
    end

    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule

// File: doc/debounce_sync.md
DEBOUNCE_SYNC -- requirements
Module: debounce_sync

Interface
REQ-001 SHALL have parameter STABLE_CNT, default 4, number of consecutive synchronized samples needed to accept a new level; legal range 2..2^CNT_W-1.
REQ-002 SHALL have parameter CNT_W, default 16, width of the internal stability counter.
REQ-003 SHALL have port clk  input  1  single clock; all flops update on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port din  input  1  raw asynchronous level, e.g. a switch or button.
REQ-006 SHALL have port dout  output  1  synchronized, debounced level, registered; drives the D input of the downstream flip-flop stage.
REQ-007 SHALL have port rise  output  1  registered one-cycle pulse when dout goes 0->1.
REQ-008 SHALL have port fall  output  1  registered one-cycle pulse when dout goes 1->0.

Function
REQ-009 SHALL pass din through a two-flop synchronizer (s1 <= din, s2 <= s1); no logic other than the FSM reads s1 or s2.
REQ-010 SHALL implement FSM states LOW (dout=0), ARM_HI (dout=0, counting), HIGH (dout=1), ARM_LO (dout=1, counting).
REQ-011 LOW: s2=1 -> ARM_HI, cnt<=1; else stay, cnt<=0.
REQ-012 ARM_HI: s2=0 -> LOW, cnt<=0; s2=1 and cnt==STABLE_CNT-1 -> HIGH, dout<=1, rise<=1, cnt<=0; otherwise cnt<=cnt+1.
REQ-013 HIGH: s2=0 -> ARM_LO, cnt<=1; else stay, cnt<=0.
REQ-014 ARM_LO: s2=1 -> HIGH, cnt<=0; s2=0 and cnt==STABLE_CNT-1 -> LOW, dout<=0, fall<=1, cnt<=0; otherwise cnt<=cnt+1.
REQ-015 A level change SHALL be accepted only after s2 holds the new level for STABLE_CNT consecutive samples; any opposite sample restarts qualification and leaves dout unchanged.
REQ-016 Latency: din settles to a new level before edge k and stays there -> dout and the matching pulse SHALL take the new value at edge k+STABLE_CNT+1.
REQ-017 rise and fall SHALL each be high for exactly one cycle, the first cycle of the new dout level; they SHALL never be high together, and SHALL be 0 in every other cycle.
REQ-018 cnt SHALL never exceed STABLE_CNT-1; there is no counter wrap-around.
REQ-019 dout SHALL change only on LOW<->HIGH completion; ARM_HI and ARM_LO hold the previous level.
REQ-020 Illegal state encodings SHALL return to LOW with cnt=0 on the next edge.

Reset
REQ-021 When rst=1 at a rising clk edge: s1=0, s2=0, state=LOW, cnt=0, dout=0, rise=0, fall=0.
REQ-022 rst SHALL override all other behaviour, including mid-qualification (ARM_HI/ARM_LO), and SHALL produce no rise or fall pulse.
REQ-023 After rst deasserts, din=1 held from the first edge (edge 0) SHALL give dout=1 at edge STABLE_CNT+1, per REQ-016.

Verification
REQ-024 STABLE_CNT=4: rst for 2 cycles, then din=1 from edge 0 -> dout=1 and rise=1 after edge 5; rise=0 after edge 6; fall stays 0.
REQ-025 STABLE_CNT=4, dout=0: din=1 for 3 cycles then 0 -> dout, rise and fall stay 0 throughout.
REQ-026 STABLE_CNT=4, dout=1: din toggles 0,1,0,1 every cycle for 20 cycles, then holds 0 -> dout stays 1 through the toggling, falls 5 edges after the final hold begins, with a single fall pulse.
REQ-027 STABLE_CNT=4: rst=1 while in ARM_HI with cnt=2 -> after that edge dout=0, cnt=0, state=LOW, no pulse; with din still 1, dout=1 at edge 5 after rst drops.
REQ-028 STABLE_CNT=2: din alternates between 10-cycle high and 10-cycle low phases for 100 cycles -> every dout edge lags its din edge by exactly 3 cycles; one pulse per dout edge; rise count equals fall count ±1.
